// File: rtl/pairing_serial_port_if.sv
// Pin-side serial channels and core-side operand/result buses of the pairing serial port.
// PAIRING_PORT_PARITY_EN adds the in_parity_err status line.
interface pairing_serial_port_if #(
    parameter int DATA_W = 198,
    parameter int LANES  = 1
);
    logic [LANES-1:0]  s_in;
    logic              s_in_valid;
    logic              s_in_ready;
    logic              in_full;
    logic              in_ack;
    logic              in_abort;
    logic [DATA_W-1:0] core_din;
    logic [DATA_W-1:0] core_dout;
    logic              capture;
    logic [LANES-1:0]  s_out;
    logic              s_out_valid;
    logic              s_out_ready;
    logic              out_overrun;
    logic              busy;
`ifdef PAIRING_PORT_PARITY_EN
    logic              in_parity_err;
`endif

    // master: the pins/core environment; slave: the port itself
    modport master (
        output s_in, s_in_valid, in_ack, in_abort, core_dout, capture, s_out_ready,
`ifdef PAIRING_PORT_PARITY_EN
        input  in_parity_err,
`endif
        input  s_in_ready, in_full, core_din, s_out, s_out_valid, out_overrun, busy
    );

    modport slave (
        input  s_in, s_in_valid, in_ack, in_abort, core_dout, capture, s_out_ready,
`ifdef PAIRING_PORT_PARITY_EN
        output in_parity_err,
`endif
        output s_in_ready, in_full, core_din, s_out, s_out_valid, out_overrun, busy
    );
endinterface

// File: rtl/pairing_serial_port.sv
// Serial bridge between narrow pins and the wide pairing-core operand/result buses.
// Build option PAIRING_PORT_PARITY_EN appends an even-parity beat to each frame.
//
// state     | meaning
// IN_RECV   | shifting input beats into r_reg_in, s_in_ready high
// IN_FULL   | complete operand on core_din, waiting for in_ack
// OUT_IDLE  | no result frame in flight, waiting for capture
// OUT_SEND  | presenting r_reg_out beats on s_out until the final handshake
module pairing_serial_port #(
    parameter int DATA_W = 198,
    parameter int LANES  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    pairing_serial_port_if.slave   bus
);
    localparam int BEATS = (DATA_W + LANES - 1) / LANES;
    localparam int W_PAD = BEATS * LANES;
`ifdef PAIRING_PORT_PARITY_EN
    localparam int PAR_BEATS = 1;
`else
    localparam int PAR_BEATS = 0;
`endif
    localparam int F_BEATS = BEATS + PAR_BEATS;
    localparam int F_W     = F_BEATS * LANES;
    localparam int CNT_W   = $clog2(F_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(F_BEATS - 1);

    typedef enum logic { IN_RECV, IN_FULL } in_state_t;
    typedef enum logic { OUT_IDLE, OUT_SEND } out_state_t;

    in_state_t        r_in_state;
    logic [CNT_W-1:0] r_in_cnt;
    logic [F_W-1:0]   r_reg_in;
    logic             r_s_in_ready;
    logic             r_in_full;

    out_state_t       r_out_state;
    logic [CNT_W-1:0] r_out_cnt;
    logic [F_W-1:0]   r_reg_out;
    logic             r_s_out_valid;
    logic             r_out_overrun;

    logic             w_in_beat;
    logic [F_W-1:0]   w_in_next;
    logic             w_out_hs;
    logic             w_out_last;
    logic [F_W-1:0]   w_out_load;

    // New beat enters at the top; after a full frame the first beat sits at bit 0.
    assign w_in_beat = bus.s_in_valid & r_s_in_ready;
    assign w_in_next = (r_reg_in >> LANES) | (F_W'(bus.s_in) << (F_W - LANES));

    assign w_out_hs   = r_s_out_valid & bus.s_out_ready;
    assign w_out_last = w_out_hs & (r_out_cnt == LAST_BEAT);

`ifdef PAIRING_PORT_PARITY_EN
    logic r_in_parity_err;
    logic w_parity_bad;

    // Parity beat lands just above the padded data field, so it shifts out after the data.
    assign w_out_load   = F_W'(bus.core_dout) | (F_W'(^bus.core_dout) << W_PAD);
    assign w_parity_bad = (^w_in_next[DATA_W-1:0]) ^ w_in_next[W_PAD];
    assign bus.in_parity_err = r_in_parity_err;
`else
    assign w_out_load = F_W'(bus.core_dout);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_state   <= IN_RECV;
            r_in_cnt     <= '0;
            r_reg_in     <= '0;
            r_s_in_ready <= 1'b1;
            r_in_full    <= 1'b0;
`ifdef PAIRING_PORT_PARITY_EN
            r_in_parity_err <= 1'b0;
`endif
        end else if (bus.in_abort) begin
            r_in_state   <= IN_RECV;
            r_in_cnt     <= '0;
            r_reg_in     <= '0;
            r_s_in_ready <= 1'b1;
            r_in_full    <= 1'b0;
`ifdef PAIRING_PORT_PARITY_EN
            r_in_parity_err <= 1'b0;
`endif
        end else begin
            case (r_in_state)
                IN_RECV: begin
                    if (w_in_beat) begin
                        r_reg_in <= w_in_next;
                        if (r_in_cnt == LAST_BEAT) begin
                            r_in_cnt     <= '0;
                            r_in_state   <= IN_FULL;
                            r_s_in_ready <= 1'b0;
                            r_in_full    <= 1'b1;
`ifdef PAIRING_PORT_PARITY_EN
                            r_in_parity_err <= w_parity_bad;
`endif
                        end else begin
                            r_in_cnt <= r_in_cnt + 1'b1;
                        end
                    end
                end
                IN_FULL: begin
                    if (bus.in_ack) begin
                        r_in_state   <= IN_RECV;
                        r_s_in_ready <= 1'b1;
                        r_in_full    <= 1'b0;
`ifdef PAIRING_PORT_PARITY_EN
                        r_in_parity_err <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_in_state   <= IN_RECV;
                    r_s_in_ready <= 1'b1;
                    r_in_full    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_state   <= OUT_IDLE;
            r_out_cnt     <= '0;
            r_reg_out     <= '0;
            r_s_out_valid <= 1'b0;
            r_out_overrun <= 1'b0;
        end else begin
            case (r_out_state)
                OUT_IDLE: begin
                    if (bus.capture) begin
                        r_reg_out     <= w_out_load;
                        r_out_cnt     <= '0;
                        r_out_state   <= OUT_SEND;
                        r_s_out_valid <= 1'b1;
                        r_out_overrun <= 1'b0;
                    end
                end
                OUT_SEND: begin
                    // A capture landing on the final handshake chains frames without a bubble.
                    if (bus.capture && w_out_last) begin
                        r_reg_out <= w_out_load;
                        r_out_cnt <= '0;
                    end else begin
                        if (bus.capture) begin
                            r_out_overrun <= 1'b1;
                        end
                        if (w_out_hs) begin
                            r_reg_out <= r_reg_out >> LANES;
                            if (w_out_last) begin
                                r_out_cnt     <= '0;
                                r_out_state   <= OUT_IDLE;
                                r_s_out_valid <= 1'b0;
                            end else begin
                                r_out_cnt <= r_out_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_out_state   <= OUT_IDLE;
                    r_s_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_in_ready  = r_s_in_ready;
    assign bus.in_full     = r_in_full;
    assign bus.core_din    = r_reg_in[DATA_W-1:0];
    assign bus.s_out       = r_reg_out[LANES-1:0];
    assign bus.s_out_valid = r_s_out_valid;
    assign bus.out_overrun = r_out_overrun;
    assign bus.busy        = (r_in_cnt != '0) | (r_out_state == OUT_SEND);
endmodule

// File: tb/tb_pairing_serial_port.sv
// Directed bench: a LANES=1 port exercises the input channel, a LANES=4 port the output channel.
module tb_pairing_serial_port;
   localparam int DW = 198;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   pairing_serial_port_if #(.DATA_W(DW), .LANES(1)) bus1 ();
   pairing_serial_port_if #(.DATA_W(DW), .LANES(4)) bus4 ();

   pairing_serial_port #(.DATA_W(DW), .LANES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   pairing_serial_port #(.DATA_W(DW), .LANES(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

   logic [DW-1:0] pat1, pat2, pat3, pat_a, pat_b, one_top;
   logic [199:0]  pad;
   int            idx;
   int            cyc;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [DW-1:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         bus1.s_in       = d[i];
         bus1.s_in_valid = 1'b1;
         tick();
      end
      bus1.s_in_valid = 1'b0;
   endtask

   initial begin
      pat1    = {2'b11, 4'h5, {24{8'hA5}}};
      pat2    = ~pat1;
      pat3    = {66{3'b110}};
      pat_a   = pat1 ^ {99{2'b10}};
      pat_b   = {pat2[98:0], pat3[98:0]};
      one_top = '0;
      one_top[DW-1] = 1'b1;

      bus1.s_in = '0; bus1.s_in_valid = 1'b0; bus1.in_ack = 1'b0; bus1.in_abort = 1'b0;
      bus1.core_dout = '0; bus1.capture = 1'b0; bus1.s_out_ready = 1'b0;
      bus4.s_in = '0; bus4.s_in_valid = 1'b0; bus4.in_ack = 1'b0; bus4.in_abort = 1'b0;
      bus4.core_dout = '0; bus4.capture = 1'b0; bus4.s_out_ready = 1'b0;

      tick(); tick();
      chk("rst_s_in_ready", bus1.s_in_ready, 1'b1);
      chk("rst_in_full", bus1.in_full, 1'b0);
      chk("rst_core_din", bus1.core_din, {DW{1'b0}});
      chk("rst_s_out", bus4.s_out, 4'h0);
      chk("rst_s_out_valid", bus4.s_out_valid, 1'b0);
      chk("rst_overrun", bus4.out_overrun, 1'b0);
      chk("rst_busy", bus1.busy, 1'b0);
      reset = 1'b1;
      tick();

      // full 198-beat frame, valid held high
      send1(pat1, DW - 1);
      chk("in_full_early", bus1.in_full, 1'b0);
      chk("busy_mid_in", bus1.busy, 1'b1);
      bus1.s_in = pat1[DW-1]; bus1.s_in_valid = 1'b1;
      tick();
      chk("in_full_rise", bus1.in_full, 1'b1);
      chk("full_not_ready", bus1.s_in_ready, 1'b0);
      chk("core_din_pat1", bus1.core_din, pat1);
      bus1.s_in = 1'b0;
      tick(); tick(); tick();
      chk("full_ignores_beats", bus1.core_din, pat1);
      chk("full_held", bus1.in_full, 1'b1);
      bus1.s_in_valid = 1'b0;
      bus1.in_ack = 1'b1;
      tick();
      bus1.in_ack = 1'b0;
      chk("ack_clears_full", bus1.in_full, 1'b0);
      chk("ack_ready", bus1.s_in_ready, 1'b1);
      chk("ack_retains_din", bus1.core_din, pat1);

      // abort after 100 beats (with a coincident beat), then a clean frame
      send1(pat2, 100);
      chk("busy_partial", bus1.busy, 1'b1);
      bus1.in_abort = 1'b1; bus1.s_in = 1'b1; bus1.s_in_valid = 1'b1;
      tick();
      bus1.in_abort = 1'b0; bus1.s_in_valid = 1'b0;
      chk("abort_din_zero", bus1.core_din, {DW{1'b0}});
      chk("abort_busy", bus1.busy, 1'b0);
      send1(pat3, DW);
      chk("second_frame_full", bus1.in_full, 1'b1);
      chk("second_frame_din", bus1.core_din, pat3);
      bus1.in_abort = 1'b1; bus1.in_ack = 1'b1;
      tick();
      bus1.in_abort = 1'b0; bus1.in_ack = 1'b0;
      chk("abort_full_clr", bus1.in_full, 1'b0);
      chk("abort_full_ready", bus1.s_in_ready, 1'b1);
      chk("abort_full_din", bus1.core_din, {DW{1'b0}});

      // 1<<197 over 50 beats of 4 lanes: only beat 49 is nonzero
      bus4.s_out_ready = 1'b1;
      bus4.core_dout = one_top;
      bus4.capture = 1'b1;
      tick();
      bus4.capture = 1'b0;
      chk("out_busy", bus4.busy, 1'b1);
      for (int k = 0; k < 50; k++) begin
         chk("onehot_valid", bus4.s_out_valid, 1'b1);
         chk("onehot_beat", bus4.s_out, ((k == 49) ? 4'h2 : 4'h0));
         tick();
      end
      chk("onehot_done_valid", bus4.s_out_valid, 1'b0);
      chk("onehot_done_busy", bus4.busy, 1'b0);

      // sink stalls every other cycle
      pad = {2'b00, pat1};
      bus4.s_out_ready = 1'b0;
      bus4.core_dout = pat1;
      bus4.capture = 1'b1;
      tick();
      bus4.capture = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < 50 && cyc < 400) begin
         bus4.s_out_ready = cyc[0];
         chk("stall_valid", bus4.s_out_valid, 1'b1);
         chk("stall_beat", bus4.s_out, pad[idx*4 +: 4]);
         tick();
         if (cyc[0]) idx++;
         cyc++;
      end
      if (cyc >= 400) begin
         errors++;
         $error("FAIL stall_timeout: wait expired after %0d cycles with %0d handshakes", cyc, idx);
      end
      bus4.s_out_ready = 1'b1;
      chk("stall_handshakes", idx, 50);
      chk("stall_done_valid", bus4.s_out_valid, 1'b0);

      // capture while draining at out_cnt=10: overrun, frame unchanged
      pad = {2'b00, pat2};
      bus4.core_dout = pat2;
      bus4.capture = 1'b1;
      tick();
      bus4.capture = 1'b0;
      chk("ovr_initial", bus4.out_overrun, 1'b0);
      for (int k = 0; k < 50; k++) begin
         chk("ovr_beat", bus4.s_out, pad[k*4 +: 4]);
         if (k == 11) chk("ovr_set", bus4.out_overrun, 1'b1);
         bus4.capture = (k == 10);
         if (k == 10) bus4.core_dout = pat3;
         tick();
      end
      bus4.capture = 1'b0;
      chk("ovr_sticky", bus4.out_overrun, 1'b1);
      chk("ovr_done_valid", bus4.s_out_valid, 1'b0);

      // IDLE capture clears overrun; capture on final handshake chains frames
      pad = {2'b00, pat_a};
      bus4.core_dout = pat_a;
      bus4.capture = 1'b1;
      tick();
      bus4.capture = 1'b0;
      chk("ovr_cleared", bus4.out_overrun, 1'b0);
      for (int k = 0; k < 50; k++) begin
         chk("b2b_a_beat", bus4.s_out, pad[k*4 +: 4]);
         if (k == 49) begin
            bus4.core_dout = pat_b;
            bus4.capture = 1'b1;
         end
         tick();
      end
      bus4.capture = 1'b0;
      chk("b2b_no_bubble", bus4.s_out_valid, 1'b1);
      chk("b2b_no_overrun", bus4.out_overrun, 1'b0);
      pad = {2'b00, pat_b};
      for (int k = 0; k < 50; k++) begin
         chk("b2b_b_beat", bus4.s_out, pad[k*4 +: 4]);
         tick();
      end
      chk("b2b_done_valid", bus4.s_out_valid, 1'b0);

      // reset while both channels are mid-frame
      bus4.core_dout = pat_a;
      bus4.capture = 1'b1;
      tick();
      bus4.capture = 1'b0;
      send1(pat1, 20);
      chk("pre_rst_valid", bus4.s_out_valid, 1'b1);
      reset = 1'b0;
      tick();
      chk("mid_rst_valid", bus4.s_out_valid, 1'b0);
      chk("mid_rst_s_out", bus4.s_out, 4'h0);
      chk("mid_rst_busy4", bus4.busy, 1'b0);
      chk("mid_rst_din", bus1.core_din, {DW{1'b0}});
      chk("mid_rst_busy1", bus1.busy, 1'b0);
      chk("mid_rst_ready", bus1.s_in_ready, 1'b1);
      reset = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pairing_serial_port.md
Name: pairing_serial_port

Overview:
Parametrised serial I/O bridge between a narrow off-chip pin interface and the wide operand/result buses of the pairing arithmetic core. Next-generation serial front end: configurable lane width, valid/ready handshakes on both directions, beat counters, frame-complete and overrun status. Input and output channels are independent, so a new operand can load while the previous result drains.

Parameters:
DATA_W, 198, width of core operand/result bus in bits
LANES, 1, serial bits transferred per beat (1..DATA_W)
BEATS, (DATA_W+LANES-1)/LANES, derived: beats per frame; W_PAD = BEATS*LANES

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low; all state cleared on the clk edge where reset=0
s_in  input  LANES  serial input beat, LSB-first frame order
s_in_valid  input  1  s_in holds a beat
s_in_ready  output  1  port accepts a beat this cycle
in_full  output  1  complete operand frame present on core_din
in_ack  input  1  consumer has taken core_din; re-arms input channel
in_abort  input  1  discard partial or complete input frame
core_din  output  DATA_W  assembled operand to core
core_dout  input  DATA_W  result bus from core
capture  input  1  pulse: latch core_dout and begin serial output
s_out  output  LANES  serial output beat, LSB-first
s_out_valid  output  1  s_out holds a beat
s_out_ready  input  1  sink accepts s_out this cycle
out_overrun  output  1  sticky: capture arrived while output frame still draining
busy  output  1  in_cnt!=0 or output channel in SEND

Behaviour:
- Reset values: s_in_ready=1, in_full=0, core_din=0, s_out=0, s_out_valid=0, out_overrun=0, busy=0; in_cnt=0, out_cnt=0; input state RECV, output state IDLE. Reset mid-frame discards all data.
- Input FSM RECV/FULL. RECV: s_in_ready=1; beat accepted when s_in_valid&s_in_ready; reg_in (W_PAD bits) <= {s_in, reg_in[W_PAD-1:LANES]}; in_cnt++. On the accepted beat with in_cnt==BEATS-1: in_cnt<=0, go FULL next cycle.
- FULL: in_full=1, s_in_ready=0, beats ignored. in_ack -> RECV next cycle; reg_in retained until overwritten by shifting.
- core_din = reg_in[DATA_W-1:0]; padding bits of final beat (W_PAD-DATA_W MSBs) discarded.
- in_abort (either state): next cycle reg_in=0, in_cnt=0, RECV. in_abort has priority over a simultaneous beat or in_ack.
- Output FSM IDLE/SEND. capture in IDLE: reg_out <= zero-extended core_dout, out_cnt=0, SEND next cycle.
- SEND: s_out_valid=1, s_out=reg_out[LANES-1:0]; on s_out_valid&s_out_ready: reg_out>>=LANES, out_cnt++. Final handshake (out_cnt==BEATS-1) -> IDLE. s_out holds stable while not accepted.
- capture in SEND: if coincident with final handshake, new frame latched, stays SEND, out_cnt=0 (back-to-back, no bubble, no overrun); otherwise ignored and out_overrun<=1. out_overrun cleared only by reset or by a capture accepted in IDLE.
- Latency: capture to first s_out_valid = 1 cycle; last input beat to in_full = 1 cycle.
- Throughput: one beat per cycle per channel when handshakes held high.

Optional Feature:
PAIRING_PORT_PARITY_EN. Defined: input frame has one extra beat after BEATS beats; its bit 0 is even parity over all DATA_W data bits; adds output in_parity_err (1 bit, reset 0), updated when FULL is entered (1 = mismatch), cleared by in_ack/in_abort; output frame likewise appends one parity beat (bit 0 parity, upper bits 0). Undefined: no parity beat, no in_parity_err port, frames exactly BEATS beats.

Test Plan:
DATA_W=198, LANES=1: shift 198 beats of pattern 0x3...A5 with valid always high -> in_full rises cycle after beat 198, core_din equals pattern, s_in_ready=0 until in_ack.
DATA_W=198, LANES=4 (BEATS=50): core_dout=1<<197, capture -> 50 beats, beat 49 s_out=4'b0010, all others 0, then s_out_valid=0.
Output with s_out_ready toggling every other cycle -> s_out stable during stalls, 50 handshakes total, no lost/duplicated beats.
capture at out_cnt=10 -> out_overrun=1, frame continues unchanged; capture coincident with final handshake -> new frame starts next cycle, out_overrun stays 0.
in_abort after 100 of 198 beats, then full 198-beat frame -> core_din equals only second frame; reset=0 mid-output -> s_out_valid=0 next cycle.
Parity build: frame with wrong parity beat -> in_parity_err=1 with in_full; in_ack clears it.
